// File: rtl/output_holder_pkg.sv
// Shared stream-cipher types consumed by the output holder and output mux.
// Holds the holder state enum and the default buffer depth.
package output_holder_pkg;

    typedef enum logic {
        EMPTY = 1'b0,
        READY = 1'b1
    } output_holder_state_t;

    localparam int OUTPUT_HOLDER_DEPTH_DEFAULT = 2;

endpackage

// File: rtl/output_holder_if.sv
// Byte stream handshake from the cipher core into the output holder.
// master = cipher core (drives in_data/in_valid), slave = holder (drives in_ready).
interface output_holder_if;

    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready
    );

endinterface

// File: rtl/output_holder_ack_edge_detect.sv
// Rising-edge detector for the output_acknowledge chip pin.
// Ports: clk, rst (async high), pin (raw ack), rise (one-cycle pulse).
// OUTPUT_HOLDER_ACK_SYNC_EN adds a 2-flop synchronizer ahead of the detector.
module ack_edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic pin,
    output logic rise
);

    logic ack_in;
    logic ack_q;

`ifdef OUTPUT_HOLDER_ACK_SYNC_EN
    logic [1:0] sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], pin};
        end
    end

    assign ack_in = sync_q[1];
`else
    // Pin is guaranteed synchronous to clk by the integrator.
    assign ack_in = pin;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ack_q <= 1'b0;
        end else begin
            ack_q <= ack_in;
        end
    end

    // A pin held high yields a single pulse.
    assign rise = ack_in & ~ack_q;

endmodule

// File: rtl/output_holder.sv
// Byte FIFO between cipher core and output mux; pops on ack pin rising edge.
// Ports: clk, rst, in_bus (slave handshake), flush, output_acknowledge,
// data_out, output_holder_state, count. Option: OUTPUT_HOLDER_ACK_SYNC_EN.
module output_holder
    import output_holder_pkg::*;
#(
    parameter  int DEPTH = OUTPUT_HOLDER_DEPTH_DEFAULT,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    output_holder_if.slave       in_bus,
    input  logic                 flush,
    input  logic                 output_acknowledge,
    output logic [7:0]           data_out,
    output output_holder_state_t output_holder_state,
    output logic [PTR_W:0]       count
);

    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W + 1)'(1);
    localparam logic [PTR_W:0]   CNT_FULL = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    logic [7:0]           mem [DEPTH];
    logic [PTR_W-1:0]     wptr_q, wptr_d;
    logic [PTR_W-1:0]     rptr_q, rptr_d;
    logic [PTR_W:0]       count_q, count_d;
    logic [PTR_W:0]       remain;
    logic [7:0]           dout_q, dout_d;
    output_holder_state_t state_q, state_d;
    logic                 ack_rise;
    logic                 push;
    logic                 pop;

    ack_edge_detect u_ack (
        .clk  (clk),
        .rst  (rst),
        .pin  (output_acknowledge),
        .rise (ack_rise)
    );

    // Depends on registered count only.
    assign in_bus.in_ready = (count_q < CNT_FULL);

    assign push = in_bus.in_valid & in_bus.in_ready & ~flush;
    assign pop  = ack_rise & (count_q != '0) & ~flush;

    // Entries left once this cycle's pop is applied, before any push.
    assign remain = pop ? (count_q - CNT_ONE) : count_q;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        dout_d  = dout_q;
        state_d = state_q;
        if (flush) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
            state_d = EMPTY;
        end else begin
            if (push) begin
                wptr_d = wptr_q + PTR_ONE;
            end
            if (pop) begin
                rptr_d = rptr_q + PTR_ONE;
            end
            unique case ({push, pop})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
            unique case (state_q)
                EMPTY: begin
                    if (push) begin
                        state_d = READY;
                    end
                end
                READY: begin
                    if (pop && !push && count_q == CNT_ONE) begin
                        state_d = EMPTY;
                    end
                end
                default: state_d = EMPTY;
            endcase
            // New head: bypass the incoming byte if nothing else remains,
            // otherwise the stored entry; empty keeps the last popped value.
            if (push && remain == '0) begin
                dout_d = in_bus.in_data;
            end else if (remain != '0) begin
                dout_d = mem[rptr_d];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr_q] <= in_bus.in_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            dout_q  <= 8'h00;
            state_q <= EMPTY;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            dout_q  <= dout_d;
            state_q <= state_d;
        end
    end

    assign data_out            = dout_q;
    assign output_holder_state = state_q;
    assign count               = count_q;

endmodule

// File: tb/tb_output_holder.sv
// Directed self-checking bench for output_holder (DEPTH=2).
// Inputs driven and outputs checked on the falling edge.
module tb_output_holder;
    import output_holder_pkg::*;

`ifdef OUTPUT_HOLDER_ACK_SYNC_EN
    localparam int ACK_LAT = 3;
`else
    localparam int ACK_LAT = 1;
`endif

    logic                 clk;
    logic                 rst;
    logic                 flush;
    logic                 ack_pin;
    logic [7:0]           data_out;
    output_holder_state_t st;
    logic [1:0]           count;

    int errors;
    int checks;

    output_holder_if bus ();

    output_holder #(.DEPTH(2)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .in_bus              (bus),
        .flush               (flush),
        .output_acknowledge  (ack_pin),
        .data_out            (data_out),
        .output_holder_state (st),
        .count               (count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic push_byte(input logic [7:0] b);
        bus.in_data  = b;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic ack_pulse();
        ack_pin = 1'b1;
        repeat (ACK_LAT) tick();
        ack_pin = 1'b0;
        repeat (ACK_LAT) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        flush = 1'b0;
        ack_pin = 1'b0;
        bus.in_data = 8'h00;
        bus.in_valid = 1'b0;
        repeat (2) tick();
        checks++;
        if (st !== EMPTY || bus.in_ready !== 1'b1 || count !== 2'd0 || data_out !== 8'h00) begin
            errors++;
            $display("FAIL reset_vals: st=%0d rdy=%b cnt=%0d dout=%h need 0 1 0 00", st, bus.in_ready, count, data_out);
        end
        rst = 1'b0;
        tick();
        ack_pulse();
        tick();
        checks++;
        if (st !== EMPTY || bus.in_ready !== 1'b1 || count !== 2'd0 || data_out !== 8'h00) begin
            errors++;
            $display("FAIL empty_ack: st=%0d rdy=%b cnt=%0d dout=%h need 0 1 0 00", st, bus.in_ready, count, data_out);
        end
    endtask

    task automatic test_single();
        push_byte(8'hA5);
        checks++;
        if (data_out !== 8'hA5 || st !== READY || count !== 2'd1) begin
            errors++;
            $display("FAIL single_push: dout=%h st=%0d cnt=%0d need a5 1 1", data_out, st, count);
        end
        tick();
        checks++;
        if (count !== 2'd1) begin
            errors++;
            $display("FAIL ack_not_remembered: cnt=%0d need 1", count);
        end
        ack_pin = 1'b1;
        repeat (ACK_LAT - 1) tick();
        checks++;
        if (count !== 2'd1) begin
            errors++;
            $display("FAIL single_prepop: cnt=%0d need 1", count);
        end
        tick();
        checks++;
        if (count !== 2'd0 || st !== EMPTY) begin
            errors++;
            $display("FAIL single_pop_edge: cnt=%0d st=%0d need 0 0", count, st);
        end
        ack_pin = 1'b0;
        repeat (ACK_LAT) tick();
        checks++;
        if (data_out !== 8'hA5 || count !== 2'd0) begin
            errors++;
            $display("FAIL single_hold: dout=%h cnt=%0d need a5 0", data_out, count);
        end
    endtask

    task automatic test_back_to_back();
        push_byte(8'h11);
        push_byte(8'h22);
        checks++;
        if (count !== 2'd2 || bus.in_ready !== 1'b0 || data_out !== 8'h11) begin
            errors++;
            $display("FAIL b2b_full: cnt=%0d rdy=%b dout=%h need 2 0 11", count, bus.in_ready, data_out);
        end
        bus.in_data = 8'h33;
        bus.in_valid = 1'b1;
        tick();
        checks++;
        if (count !== 2'd2 || data_out !== 8'h11) begin
            errors++;
            $display("FAIL b2b_stall: cnt=%0d dout=%h need 2 11", count, data_out);
        end
        ack_pin = 1'b1;
        repeat (ACK_LAT) tick();
        checks++;
        if (data_out !== 8'h22 || count !== 2'd1 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_pop1: dout=%h cnt=%0d rdy=%b need 22 1 1", data_out, count, bus.in_ready);
        end
        tick();
        bus.in_valid = 1'b0;
        ack_pin = 1'b0;
        checks++;
        if (count !== 2'd2 || data_out !== 8'h22) begin
            errors++;
            $display("FAIL b2b_accept33: cnt=%0d dout=%h need 2 22", count, data_out);
        end
        repeat (ACK_LAT) tick();
        ack_pulse();
        checks++;
        if (data_out !== 8'h33 || count !== 2'd1) begin
            errors++;
            $display("FAIL b2b_pop2: dout=%h cnt=%0d need 33 1", data_out, count);
        end
        ack_pulse();
        checks++;
        if (count !== 2'd0 || st !== EMPTY || data_out !== 8'h33) begin
            errors++;
            $display("FAIL b2b_pop3: cnt=%0d st=%0d dout=%h need 0 0 33", count, st, data_out);
        end
    endtask

    task automatic test_hold_ack();
        push_byte(8'h66);
        push_byte(8'h77);
        ack_pin = 1'b1;
        repeat (10 + ACK_LAT) tick();
        checks++;
        if (count !== 2'd1 || data_out !== 8'h77) begin
            errors++;
            $display("FAIL hold_ack: cnt=%0d dout=%h need 1 77", count, data_out);
        end
        ack_pin = 1'b0;
        repeat (ACK_LAT) tick();
        ack_pulse();
        checks++;
        if (count !== 2'd0 || st !== EMPTY) begin
            errors++;
            $display("FAIL hold_drain: cnt=%0d st=%0d need 0 0", count, st);
        end
    endtask

    task automatic test_simul();
        push_byte(8'h88);
        ack_pin = 1'b1;
        repeat (ACK_LAT - 1) tick();
        bus.in_data = 8'h44;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        checks++;
        if (count !== 2'd1 || data_out !== 8'h44 || st !== READY) begin
            errors++;
            $display("FAIL simul_push_pop: cnt=%0d dout=%h st=%0d need 1 44 1", count, data_out, st);
        end
        ack_pin = 1'b0;
        repeat (ACK_LAT) tick();
        ack_pulse();
        checks++;
        if (count !== 2'd0 || data_out !== 8'h44) begin
            errors++;
            $display("FAIL simul_drain: cnt=%0d dout=%h need 0 44", count, data_out);
        end
    endtask

    task automatic test_flush();
        push_byte(8'h99);
        push_byte(8'hAA);
        flush = 1'b1;
        bus.in_data = 8'h55;
        bus.in_valid = 1'b1;
        tick();
        flush = 1'b0;
        bus.in_valid = 1'b0;
        checks++;
        if (count !== 2'd0 || st !== EMPTY || data_out !== 8'h99 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush: cnt=%0d st=%0d dout=%h rdy=%b need 0 0 99 1", count, st, data_out, bus.in_ready);
        end
        push_byte(8'hBB);
        checks++;
        if (count !== 2'd1 || data_out !== 8'hBB) begin
            errors++;
            $display("FAIL flush_no55: cnt=%0d dout=%h need 1 bb", count, data_out);
        end
        ack_pulse();
    endtask

    task automatic test_async_reset();
        push_byte(8'hCC);
        #2 rst = 1'b1;
        #1;
        checks++;
        if (count !== 2'd0 || st !== EMPTY || data_out !== 8'h00) begin
            errors++;
            $display("FAIL async_reset: cnt=%0d st=%0d dout=%h need 0 0 00", count, st, data_out);
        end
        @(negedge clk);
        rst = 1'b0;
        tick();
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_single();
        test_back_to_back();
        test_hold_ack();
        test_simul();
        test_flush();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/output_holder.md
Name: output_holder

Overview:
- Sits between the stream cipher core and the output mux stage.
- Accepts ciphertext/plaintext bytes from the core over a valid/ready handshake and buffers them in a small FIFO.
- Presents the head byte plus an `output_holder_state_t` to the output mux.
- Pops the head byte only when the chip user pulses the `output_acknowledge` pin (rising edge). Backpressure stalls the core while the buffer is full.

Parameters:
- DEPTH, 2, number of byte entries buffered; power of two, minimum 2.
- PTR_W, $clog2(DEPTH), pointer width; derived, not overridden.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  asynchronous, active-high reset
- in_data  input  8  byte from cipher core
- in_valid  input  1  core has a byte on in_data
- in_ready  output  1  holder can accept a byte this cycle
- flush  input  1  synchronous clear from interface fsm (session restart)
- output_acknowledge  input  1  chip pin; rising edge = user has read data_out
- data_out  output  8  head byte, to output mux data_in
- output_holder_state  output  output_holder_state_t  EMPTY or READY, to output mux
- count  output  PTR_W+1  occupancy, 0..DEPTH

Behaviour:
- Reset (async assert, sync release):
  - count=0, read/write pointers=0.
  - state=EMPTY, data_out=8'h00.
  - in_ready=1.
  - ack edge-detect register=0.
- Storage:
  - DEPTH x 8 register array, circular pointers.
  - Pointers wrap modulo DEPTH.
  - count carries full/empty; pointer equality never does.
- Push: `in_valid & in_ready` at a clock edge writes in_data at wptr, then wptr++.
- in_ready = (count < DEPTH):
  - Registered-state function only, with no combinational path from output_acknowledge or in_valid.
  - When full, no push that cycle, even if a pop happens in the same cycle.
- Ack edge:
  - ack_q is output_acknowledge registered.
  - ack_rise = output_acknowledge & ~ack_q.
  - A held-high pin counts as one rise only.
- Pop: ack_rise & (count>0) at a clock edge, then rptr++.
- ack_rise with count==0 is ignored. No state change, and it is not remembered.
- Simultaneous push and pop with 0<count<DEPTH: both happen, count unchanged.
- Push into empty:
  - Byte accepted at edge N appears on data_out with state=READY after edge N.
  - One cycle latency.
- data_out:
  - Equals mem[rptr] whenever count>0.
  - Holds the last popped value when empty.
  - Never glitches to an unwritten entry.
- State machine (output_holder_state_t):
  - EMPTY -> READY on push when count==0.
  - READY -> EMPTY on pop when count==1 and no simultaneous push.
  - READY -> READY otherwise.
  - The state register must equal (count!=0) at all times.
- flush:
  - Has priority over push and pop in the same cycle.
  - Clears count and pointers and forces EMPTY.
  - Same-cycle in_valid is dropped, even though in_ready was 1.
  - data_out is unchanged.
- Reset mid-operation: all contents are discarded and the block returns to reset values immediately (async).

Optional Feature:
- Macro: OUTPUT_HOLDER_ACK_SYNC_EN.
- Defined:
  - output_acknowledge passes through a 2-flop synchronizer before the edge detector.
  - Pin rise to pop is 3 clock edges (sync, sync, edge register) instead of 1.
  - Reset clears the synchronizer flops to 0.
- Undefined:
  - The pin feeds the edge detector directly.
  - The integrator guarantees the pin is synchronous.

Decomposition:
- Shared stream-cipher package owns:
  - `typedef enum logic {EMPTY, READY} output_holder_state_t` (also consumed by the output mux).
  - Localparam OUTPUT_HOLDER_DEPTH_DEFAULT=2.
- One sub-module, `ack_edge_detect`:
  - Optional synchronizer under the macro, plus the rising-edge register.
  - Output: a single-cycle pulse.
- The FIFO core stays inline.

Test Plan:
- Reset then idle:
  - state=EMPTY, in_ready=1, count=0, data_out=8'h00.
  - An ack pulse while empty leaves all of these unchanged.
- Push 8'hA5 at edge N:
  - Edge N+1: data_out=8'hA5, state=READY, count=1.
  - One ack rise: state=EMPTY, count=0.
- Push 8'h11, 8'h22, 8'h33 back-to-back with DEPTH=2:
  - in_ready=0 after two pushes, and 8'h33 is held by the core.
  - Ack: data_out=8'h22, then 8'h33 is accepted next cycle.
  - Bytes are read out in order 11, 22, 33.
- Hold output_acknowledge high for 10 cycles with count=2: exactly one pop, count=1, data_out advances once.
- Simultaneous push 8'h44 and ack rise with count=1: count stays 1, data_out=8'h44.
- flush asserted with count=2 and in_valid=1 (8'h55) in the same cycle:
  - Next cycle count=0, state=EMPTY, and 8'h55 is not stored.
  - With OUTPUT_HOLDER_ACK_SYNC_EN, repeat the single-byte test and check the pop occurs exactly 3 edges after the pin rise.
